// File: rtl/sea_pkg.sv
// Shared types and helpers for the SEA iterative cipher: S-box, FSM states,
// round-key derivation and whole-word rotations on a generously sized half-block.
package sea_pkg;

    localparam int MAXW = 256;

    typedef logic [MAXW-1:0]   hvec_t;
    typedef logic [2*MAXW-1:0] kvec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] SBOX [8] = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd3, 3'd1, 3'd2};

    // Word k of an hw-bit half moves to word k+1 (mod NB): a left rotate by b bits.
    function automatic hvec_t rotw(input hvec_t y, input int hw, input int b);
        hvec_t r;
        r = '0;
        for (int n = 0; n < MAXW; n++)
            if (n < hw) r[(n + b) % hw] = y[n];
        return r;
    endfunction

    function automatic hvec_t rotw_inv(input hvec_t y, input int hw, input int b);
        hvec_t r;
        r = '0;
        for (int n = 0; n < MAXW; n++)
            if (n < hw) r[n] = y[(n + b) % hw];
        return r;
    endfunction

    // Even rounds use the low key half, odd rounds the high half; i lands in word 0.
    function automatic hvec_t rkey(input kvec_t key, input logic [7:0] i, input int hw, input int b);
        hvec_t mask;
        hvec_t k;
        mask = (hvec_t'(1) << hw) - hvec_t'(1);
        k = hvec_t'(i[0] ? (key >> hw) : key) & mask;
        k[7:0] = k[7:0] ^ (i & 8'((1 << b) - 1));
        return k;
    endfunction

endpackage

// File: rtl/sea_round.sv
// One combinational SEA Feistel round, encrypt or decrypt selected by dec.
// Pure logic: no latency, no flow control.
module sea_round
    import sea_pkg::*;
#(
    parameter int B  = 8,
    parameter int NB = 6
) (
    input  logic [NB*B-1:0] x_l,
    input  logic [NB*B-1:0] x_r,
    input  logic [NB*B-1:0] k,
    input  logic            dec,
    output logic [NB*B-1:0] y_l,
    output logic [NB*B-1:0] y_r
);
    localparam int HW = NB * B;

    function automatic logic [HW-1:0] f_fn(input logic [HW-1:0] x, input logic [HW-1:0] kk);
        logic [HW-1:0] a;
        logic [HW-1:0] s;
        logic [HW-1:0] f;
        logic [2:0]    v;
        logic [2:0]    sv;
        logic [B-1:0]  wd;
        for (int w = 0; w < NB; w++)
            a[w*B +: B] = x[w*B +: B] + kk[w*B +: B];
        // Bit n of each word triplet forms one 3-bit S-box input, lowest word as LSB.
        for (int j = 0; j < NB/3; j++) begin
            for (int n = 0; n < B; n++) begin
                v  = {a[(3*j+2)*B+n], a[(3*j+1)*B+n], a[3*j*B+n]};
                sv = SBOX[v];
                s[3*j*B+n]     = sv[0];
                s[(3*j+1)*B+n] = sv[1];
                s[(3*j+2)*B+n] = sv[2];
            end
        end
        for (int w = 0; w < NB; w++) begin
            wd = s[w*B +: B];
            f[w*B +: B] = {wd[B-2:0], wd[B-1]};
        end
        return f;
    endfunction

    logic [HW-1:0] fx;
    logic [HW-1:0] rot_in;
    logic [HW-1:0] rot_out;

    always_comb begin
        fx      = f_fn(dec ? x_l : x_r, k);
        rot_in  = dec ? (x_r ^ fx) : x_l;
        rot_out = dec ? HW'(rotw_inv(hvec_t'(rot_in), HW, B))
                      : HW'(rotw(hvec_t'(rot_in), HW, B));
        y_l     = dec ? rot_out : x_r;
        y_r     = dec ? x_l : (rot_out ^ fx);
    end

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA core: NR rounds after accept (NR/2 with SEA_UNROLL2_EN), result held in DONE
// until out_ready; in_ready only in IDLE, so a block never overlaps the previous one.
module sea_iter_core
    import sea_pkg::*;
#(
    parameter int B  = 8,
    parameter int NB = 6,
    parameter int NR = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dec,
    input  logic [2*NB*B-1:0] in_key,
    input  logic [NB*B-1:0]   in_l,
    input  logic [NB*B-1:0]   in_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NB*B-1:0]   out_l,
    output logic [NB*B-1:0]   out_r,
    output logic              busy
);
    localparam int HW = NB * B;

`ifdef SEA_UNROLL2_EN
    localparam logic [7:0] STEP = 8'd2;
`else
    localparam logic [7:0] STEP = 8'd1;
`endif
    localparam logic [7:0] LAST_ENC = 8'(NR) - STEP;
    localparam logic [7:0] LAST_DEC = STEP - 8'd1;

    state_t          state;
    logic [HW-1:0]   l_q;
    logic [HW-1:0]   r_q;
    logic [2*HW-1:0] key_q;
    logic            dec_q;
    logic [7:0]      idx;

    logic [HW-1:0]   k0;
    logic [HW-1:0]   l0;
    logic [HW-1:0]   r0;
    logic [HW-1:0]   l_n;
    logic [HW-1:0]   r_n;
    logic            last;

    assign k0 = HW'(rkey(kvec_t'(key_q), idx, HW, B));

    sea_round #(.B(B), .NB(NB)) u_round0 (
        .x_l (l_q),
        .x_r (r_q),
        .k   (k0),
        .dec (dec_q),
        .y_l (l0),
        .y_r (r0)
    );

`ifdef SEA_UNROLL2_EN
    logic [7:0]    idx1;
    logic [HW-1:0] k1;

    // Second round uses the neighbouring index in the direction of travel.
    assign idx1 = dec_q ? (idx - 8'd1) : (idx + 8'd1);
    assign k1   = HW'(rkey(kvec_t'(key_q), idx1, HW, B));

    sea_round #(.B(B), .NB(NB)) u_round1 (
        .x_l (l0),
        .x_r (r0),
        .k   (k1),
        .dec (dec_q),
        .y_l (l_n),
        .y_r (r_n)
    );
`else
    assign l_n = l0;
    assign r_n = r0;
`endif

    assign last = dec_q ? (idx == LAST_DEC) : (idx == LAST_ENC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            l_q   <= '0;
            r_q   <= '0;
            key_q <= '0;
            dec_q <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        l_q   <= in_l;
                        r_q   <= in_r;
                        key_q <= in_key;
                        dec_q <= in_dec;
                        idx   <= in_dec ? 8'(NR - 1) : 8'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    l_q <= l_n;
                    r_q <= r_n;
                    idx <= dec_q ? (idx - STEP) : (idx + STEP);
                    if (last) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign out_l     = l_q;
    assign out_r     = r_q;

endmodule
